mips_data_mem_mc: RTL and testbench

MIPS_DATA_MEM_MC -- requirements
Module: mips_data_mem_mc

---
 rtl/mips_data_mem_mc.sv | 186 ++++++++++++++++++
 tb/tb_mips_data_mem_mc.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mips_data_mem_mc.sv
// mips_data_mem_mc
//   Multi-cycle MIPS data memory. One access is taken in IDLE, held for a
//   fixed number of BUSY cycles, then completed with a one-cycle RESP pulse.
//   Supports lb/lh/lw/lbu/lhu/sb/sh/sw on a little-endian word array.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   sig_mem_read/write    request qualifiers (sampled only when mem_ready=1)
//   opcode                MIPS load/store opcode
//   mem_address           byte address (upper bits wrap)
//   write_data            store data
//   mem_ready             high in IDLE: a request may be accepted
//   resp_valid            one-cycle completion pulse
//   read_data             load result (held until the next completion)
//   mem_error             access rejected (held until the next completion)
module mips_data_mem_mc #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sig_mem_read,
  input  logic        sig_mem_write,
  input  logic [5:0]  opcode,
  input  logic [31:0] mem_address,
  input  logic [31:0] write_data,
  output logic        mem_ready,
  output logic        resp_valid,
  output logic [31:0] read_data,
  output logic        mem_error
);

  localparam int DEPTH = 1 << (ADDR_WIDTH - 2);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                  state_reg, state_next;
  logic [2:0]              cnt_reg;
  logic                    rd_reg, wr_reg;
  logic [5:0]              op_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [31:0]             wdata_reg;
  logic [31:0]             mem [DEPTH];
  logic [31:0]             rd_word_reg;
  logic [31:0]             read_data_reg;
  logic                    mem_error_reg;

  logic                    accept, done;
  logic                    is_load, is_store, sext;
  logic [1:0]              size;          // 0 byte, 1 half, 2 word
  logic                    misaligned, access_err;
  logic [3:0]              byte_en;
  logic [31:0]             lane_data;
  logic [31:0]             load_val;
  logic [ADDR_WIDTH-3:0]   word_idx;

  // Address bits above the array are intentionally ignored (wrap).
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_address[31:ADDR_WIDTH];

  assign accept   = (state_reg == IDLE) && (sig_mem_read || sig_mem_write);
  assign done     = (state_reg == BUSY) && (cnt_reg == 3'(LATENCY));
  assign word_idx = addr_reg[ADDR_WIDTH-1:2];

  // State register plus captured request and wait counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 3'd0;
      rd_reg    <= 1'b0;
      wr_reg    <= 1'b0;
      op_reg    <= 6'd0;
      addr_reg  <= '0;
      wdata_reg <= 32'h0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        cnt_reg   <= 3'd0;
        rd_reg    <= sig_mem_read;
        wr_reg    <= sig_mem_write;
        op_reg    <= opcode;
        addr_reg  <= mem_address[ADDR_WIDTH-1:0];
        wdata_reg <= write_data;
      end else if (state_reg == BUSY && !done) begin
        cnt_reg <= cnt_reg + 3'd1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = BUSY;
      BUSY:    if (done)   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    mem_ready  = (state_reg == IDLE);
    resp_valid = (state_reg == RESP);
  end

  // Opcode decode of the captured request.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sext     = 1'b0;
    size     = 2'd0;
    case (op_reg)
      6'b100000: begin is_load  = 1'b1; sext = 1'b1; size = 2'd0; end // lb
      6'b100001: begin is_load  = 1'b1; sext = 1'b1; size = 2'd1; end // lh
      6'b100011: begin is_load  = 1'b1;              size = 2'd2; end // lw
      6'b100100: begin is_load  = 1'b1;              size = 2'd0; end // lbu
      6'b100101: begin is_load  = 1'b1;              size = 2'd1; end // lhu
      6'b101000: begin is_store = 1'b1;              size = 2'd0; end // sb
      6'b101001: begin is_store = 1'b1;              size = 2'd1; end // sh
      6'b101011: begin is_store = 1'b1;              size = 2'd2; end // sw
      default:   ;
    endcase
  end

  // Qualifiers must match the opcode class exactly; unlisted opcodes never match.
  assign misaligned = ((size == 2'd1) && addr_reg[0]) ||
                      ((size == 2'd2) && (addr_reg[1:0] != 2'b00));
  assign access_err = !((rd_reg && !wr_reg && is_load) ||
                        (wr_reg && !rd_reg && is_store)) || misaligned;

  // Store lanes: data is replicated so every enabled lane sees its slice.
  always_comb begin
    byte_en   = 4'b0000;
    lane_data = wdata_reg;
    case (size)
      2'd0: begin
        byte_en   = 4'b0001 << addr_reg[1:0];
        lane_data = {4{wdata_reg[7:0]}};
      end
      2'd1: begin
        byte_en   = addr_reg[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{wdata_reg[15:0]}};
      end
      default: byte_en = 4'b1111;
    endcase
  end

  // Load extraction from the registered array word.
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b = rd_word_reg[8*addr_reg[1:0] +: 8];
    h = addr_reg[1] ? rd_word_reg[31:16] : rd_word_reg[15:0];
    case (size)
      2'd0:    load_val = {{24{sext & b[7]}}, b};
      2'd1:    load_val = {{16{sext & h[15]}}, h};
      default: load_val = rd_word_reg;
    endcase
  end

  // Word array: registered read every cycle (valid from the second BUSY cycle
  // onward), lane-masked write on the BUSY->RESP edge. Never reset.
  always_ff @(posedge clk) begin
    rd_word_reg <= mem[word_idx];
    if (rst_n && done && is_store && !access_err) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
      end
    end
  end

  // Completion results, held until the next completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      read_data_reg <= 32'h0;
      mem_error_reg <= 1'b0;
    end else if (done) begin
      mem_error_reg <= access_err;
      read_data_reg <= (is_load && !access_err) ? load_val : 32'h0;
    end
  end

  assign read_data = read_data_reg;
  assign mem_error = mem_error_reg;

endmodule

// File: tb/tb_mips_data_mem_mc.sv
module tb_mips_data_mem_mc;
  localparam int LAT = 2;

  localparam logic [5:0] OP_LB  = 6'b100000, OP_LH  = 6'b100001, OP_LW = 6'b100011,
                         OP_LBU = 6'b100100, OP_LHU = 6'b100101,
                         OP_SB  = 6'b101000, OP_SH  = 6'b101001, OP_SW = 6'b101011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sig_mem_read, sig_mem_write;
  logic [5:0]  opcode;
  logic [31:0] mem_address, write_data;
  logic        mem_ready, resp_valid, mem_error;
  logic [31:0] read_data;

  int vecs = 0;
  int miss = 0;

  always #5 clk = ~clk;

  mips_data_mem_mc #(.ADDR_WIDTH(10), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .sig_mem_read(sig_mem_read), .sig_mem_write(sig_mem_write),
    .opcode(opcode), .mem_address(mem_address), .write_data(write_data),
    .mem_ready(mem_ready), .resp_valid(resp_valid),
    .read_data(read_data), .mem_error(mem_error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    sig_mem_read  = 1'b0;
    sig_mem_write = 1'b0;
    opcode        = 6'd0;
    mem_address   = 32'h0;
    write_data    = 32'h0;
  endtask

  // One access. Called at posedge+1. If noisy, a conflicting sw to 0x0 is
  // held on the inputs while the DUT is busy; it must be ignored.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [5:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input logic exp_err,
                        input logic [31:0] exp_rd, input bit noisy);
    int early;
    check({tag, ".ready"}, {31'd0, mem_ready}, 32'd1);
    sig_mem_read = rd; sig_mem_write = wr; opcode = op;
    mem_address = addr; write_data = wd;
    @(posedge clk); #1;
    if (noisy) begin
      sig_mem_read = 1'b0; sig_mem_write = 1'b1; opcode = OP_SW;
      mem_address = 32'h0; write_data = 32'hFFFF_FFFF;
    end else begin
      clear_inputs();
    end
    early = 0;
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk); #1;
      if (resp_valid) early++;
    end
    check({tag, ".early_resp"}, early, 0);
    @(posedge clk); #1;
    check({tag, ".resp_valid"}, {31'd0, resp_valid}, 32'd1);
    check({tag, ".mem_error"}, {31'd0, mem_error}, {31'd0, exp_err});
    check({tag, ".read_data"}, read_data, exp_rd);
    @(posedge clk); #1;
    clear_inputs();
    $display("%s: err=%0b data=%h", tag, mem_error, read_data);
    check({tag, ".pulse_end"}, {31'd0, resp_valid}, 32'd0);
    check({tag, ".hold"}, read_data, exp_rd);
  endtask

  initial begin
    int seen;
    clear_inputs();
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    check("reset.ready", {31'd0, mem_ready}, 32'd1);
    check("reset.resp_valid", {31'd0, resp_valid}, 32'd0);
    check("reset.mem_error", {31'd0, mem_error}, 32'd0);
    check("reset.read_data", read_data, 32'h0);

    access("sw_4",   1'b0, 1'b1, OP_SW,  32'h4, 32'h8765_43A1, 1'b0, 32'h0, 1'b0);
    access("lw_4",   1'b1, 1'b0, OP_LW,  32'h4, 32'h0, 1'b0, 32'h8765_43A1, 1'b0);
    access("lb_4",   1'b1, 1'b0, OP_LB,  32'h4, 32'h0, 1'b0, 32'hFFFF_FFA1, 1'b0);
    access("lbu_4",  1'b1, 1'b0, OP_LBU, 32'h4, 32'h0, 1'b0, 32'h0000_00A1, 1'b0);
    access("lh_6",   1'b1, 1'b0, OP_LH,  32'h6, 32'h0, 1'b0, 32'hFFFF_8765, 1'b0);
    access("lhu_6",  1'b1, 1'b0, OP_LHU, 32'h6, 32'h0, 1'b0, 32'h0000_8765, 1'b0);
    access("lb_7",   1'b1, 1'b0, OP_LB,  32'h7, 32'h0, 1'b0, 32'hFFFF_FF87, 1'b0);
    access("lbu_5",  1'b1, 1'b0, OP_LBU, 32'h5, 32'h0, 1'b0, 32'h0000_0043, 1'b0);

    access("sb_5",   1'b0, 1'b1, OP_SB,  32'h5, 32'h0000_0055, 1'b0, 32'h0, 1'b0);
    access("lw_4b",  1'b1, 1'b0, OP_LW,  32'h4, 32'h0, 1'b0, 32'h8765_55A1, 1'b0);
    access("sh_6",   1'b0, 1'b1, OP_SH,  32'h6, 32'h0000_1234, 1'b0, 32'h0, 1'b0);
    access("lw_4c",  1'b1, 1'b0, OP_LW,  32'h4, 32'h0, 1'b0, 32'h1234_55A1, 1'b0);

    // Rejected accesses
    access("lw_mis", 1'b1, 1'b0, OP_LW,  32'h6, 32'h0, 1'b1, 32'h0, 1'b0);
    access("sh_mis", 1'b0, 1'b1, OP_SH,  32'h3, 32'hAAAA_BBBB, 1'b1, 32'h0, 1'b0);
    access("both_q", 1'b1, 1'b1, OP_SW,  32'h4, 32'h1111_1111, 1'b1, 32'h0, 1'b0);
    access("bad_op", 1'b1, 1'b0, 6'b111111, 32'h4, 32'h0, 1'b1, 32'h0, 1'b0);
    access("st_rd",  1'b1, 1'b0, OP_SW,  32'h4, 32'h2222_2222, 1'b1, 32'h0, 1'b0);
    access("lw_4d",  1'b1, 1'b0, OP_LW,  32'h4, 32'h0, 1'b0, 32'h1234_55A1, 1'b0);

    // Reset during BUSY aborts the store
    access("sw_8",   1'b0, 1'b1, OP_SW,  32'h8, 32'h1122_3344, 1'b0, 32'h0, 1'b0);
    sig_mem_write = 1'b1; opcode = OP_SW; mem_address = 32'h8; write_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    clear_inputs();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort.ready", {31'd0, mem_ready}, 32'd1);
    check("abort.resp_valid", {31'd0, resp_valid}, 32'd0);
    seen = 0;
    for (int k = 0; k < LAT + 3; k++) begin
      @(posedge clk); #1;
      if (resp_valid) seen++;
    end
    check("abort.no_pulse", seen, 0);
    $display("abort: reset in BUSY, pulses seen=%0d", seen);
    access("lw_8",   1'b1, 1'b0, OP_LW,  32'h8, 32'h0, 1'b0, 32'h1122_3344, 1'b0);

    // Address wrap, with competing requests held while busy
    access("sw_wrap", 1'b0, 1'b1, OP_SW, 32'h0000_1000, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b1);
    access("lw_0",    1'b1, 1'b0, OP_LW, 32'h0, 32'h0, 1'b0, 32'hCAFE_F00D, 1'b1);
    access("lw_0b",   1'b1, 1'b0, OP_LW, 32'h0, 32'h0, 1'b0, 32'hCAFE_F00D, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
